// File: rtl/upg_word_assembler.sv
// UART-programming word assembler: packs received bytes little-endian into
// 32-bit words and issues one write strobe per word on the upg_* bus,
// routing the first IMEM_WORDS words to instruction memory and the rest to
// data memory. Ends the image on word count or after an idle timeout.
module upg_word_assembler #(
  parameter int ADDR_W      = 14,
  parameter int IMEM_WORDS  = 16384,
  parameter int DMEM_WORDS  = 16384,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_sel_o,
  output logic              upg_done_o
);

  localparam int TOTAL = IMEM_WORDS + DMEM_WORDS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] IMEM_C  = CNT_W'(IMEM_WORDS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [CNT_W-1:0]  word_cnt, word_cnt_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic [31:0]       buffer, buffer_n;
  logic              wen_n;
  logic [ADDR_W-1:0] adr_n;
  logic [31:0]       dat_n;
  logic              sel_n;

  // Place byte b into lane k of word w (lane 0 is the LSB).
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  k,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[8*k +: 8] = b;
    return r;
  endfunction

  // Word index at or beyond IMEM_WORDS belongs to data memory.
  function automatic logic mem_sel(input logic [CNT_W-1:0] cnt);
    return (cnt >= IMEM_C);
  endfunction

  // Address within the selected memory, truncated to the port width.
  function automatic logic [ADDR_W-1:0] mem_adr(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] off;
    off = (cnt >= IMEM_C) ? (cnt - IMEM_C) : cnt;
    return ADDR_W'(off);
  endfunction

  // Next-state, byte packing, idle timer and write-strobe generation.
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    word_cnt_n = word_cnt;
    timer_n    = timer;
    buffer_n   = buffer;
    wen_n      = 1'b0;
    adr_n      = upg_adr_o;
    dat_n      = upg_dat_o;
    sel_n      = upg_sel_o;
    case (state)
      IDLE: begin
        if (rx_valid_i) begin
          buffer_n   = put_byte(buffer, 2'd0, rx_data_i);
          byte_idx_n = 2'd1;
          timer_n    = '0;
          state_n    = RECV;
        end
      end
      RECV: begin
        if (rx_valid_i) begin
          // A byte always wins over a timeout landing in the same cycle.
          timer_n = '0;
          if (byte_idx == 2'd3) begin
            wen_n      = 1'b1;
            dat_n      = put_byte(buffer, 2'd3, rx_data_i);
            sel_n      = mem_sel(word_cnt);
            adr_n      = mem_adr(word_cnt);
            word_cnt_n = word_cnt + CNT_ONE;
            buffer_n   = '0;
            byte_idx_n = 2'd0;
            if (word_cnt == LAST_C) state_n = DONE;
          end else begin
            buffer_n   = put_byte(buffer, byte_idx, rx_data_i);
            byte_idx_n = byte_idx + 2'd1;
          end
        end else if (timer == TMR_LIM) begin
          state_n = (byte_idx != 2'd0) ? FLUSH : DONE;
        end else begin
          timer_n = timer + TMR_ONE;
        end
      end
      FLUSH: begin
        // Unreceived upper lanes are already zero in the buffer.
        wen_n      = 1'b1;
        dat_n      = buffer;
        sel_n      = mem_sel(word_cnt);
        adr_n      = mem_adr(word_cnt);
        word_cnt_n = word_cnt + CNT_ONE;
        buffer_n   = '0;
        byte_idx_n = 2'd0;
        state_n    = DONE;
      end
      default: begin
        state_n = DONE;
      end
    endcase
  end

  // State and registered bus outputs; done follows the state it enters.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state      <= IDLE;
      byte_idx   <= '0;
      word_cnt   <= '0;
      timer      <= '0;
      buffer     <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_sel_o  <= 1'b0;
      upg_done_o <= 1'b0;
    end else begin
      state      <= state_n;
      byte_idx   <= byte_idx_n;
      word_cnt   <= word_cnt_n;
      timer      <= timer_n;
      buffer     <= buffer_n;
      upg_wen_o  <= wen_n;
      upg_adr_o  <= adr_n;
      upg_dat_o  <= dat_n;
      upg_sel_o  <= sel_n;
      upg_done_o <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_upg_word_assembler.sv
// Bench for upg_word_assembler with a small image (2+2 words, 20-cycle
// timeout): directed table and sequences plus random byte streams checked
// against a byte-queue reference model.
module tb_upg_word_assembler;

  localparam int ADDR_W  = 14;
  localparam int IMEM    = 2;
  localparam int DMEM    = 2;
  localparam int TMO     = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              upg_wen;
  logic [ADDR_W-1:0] upg_adr;
  logic [31:0]       upg_dat;
  logic              upg_sel;
  logic              upg_done;

  int n_checks = 0;
  int n_fail   = 0;

  upg_word_assembler #(
    .ADDR_W(ADDR_W), .IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM), .TIMEOUT_CYC(TMO)
  ) dut (
    .upg_clk_i(clk), .upg_rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .upg_wen_o(upg_wen), .upg_adr_o(upg_adr), .upg_dat_o(upg_dat),
    .upg_sel_o(upg_sel), .upg_done_o(upg_done)
  );

  always #50 clk = ~clk;

  // Reference model: bytes of the current word, words written, idle run.
  logic [7:0]  m_q[$];
  int          m_words;
  int          m_idle;
  bit          m_started, m_done, m_flush;
  logic        e_wen, e_sel;
  logic [31:0] e_dat, e_adr;

  // Write log captured from the DUT for directed constant checks.
  logic [31:0] log_dat[$];
  logic [31:0] log_adr[$];
  logic        log_sel[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_words = 0; m_idle = 0; m_started = 0; m_done = 0; m_flush = 0;
    e_wen = 0; e_sel = 0; e_dat = 0; e_adr = 0;
  endtask

  task automatic model_emit();
    logic [31:0] w;
    w = 0;
    foreach (m_q[i]) w = w | (32'(m_q[i]) << (8 * i));
    m_q.delete();
    e_wen = 1;
    e_dat = w;
    e_sel = (m_words >= IMEM);
    e_adr = e_sel ? 32'(m_words - IMEM) : 32'(m_words);
    m_words++;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    e_wen = 0;
    if (m_done) begin
    end else if (m_flush) begin
      model_emit();
      m_flush = 0;
      m_done = 1;
    end else if (v) begin
      m_started = 1;
      m_idle = 0;
      m_q.push_back(d);
      if (m_q.size() == 4) begin
        model_emit();
        if (m_words == IMEM + DMEM) m_done = 1;
      end
    end else if (m_started) begin
      m_idle++;
      if (m_idle == TMO) begin
        if (m_q.size() != 0) m_flush = 1;
        else m_done = 1;
      end
    end
  endtask

  task automatic check_all();
    check("wen",  32'(upg_wen),  32'(e_wen));
    check("done", 32'(upg_done), 32'(m_done));
    check("dat",  upg_dat,       e_dat);
    check("adr",  32'(upg_adr),  e_adr);
    check("sel",  32'(upg_sel),  32'(e_sel));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 0;
    model_step(v, d);
    check_all();
    if (upg_wen) begin
      log_dat.push_back(upg_dat);
      log_adr.push_back(32'(upg_adr));
      log_sel.push_back(upg_sel);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    rx_valid = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    log_dat.delete(); log_adr.delete(); log_sel.delete();
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        wen;
    logic [31:0] dat;
    logic [31:0] adr;
    logic        sel;
    logic        done;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 8'h78, 1'b0, 32'h0,        32'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h56, 1'b0, 32'h0,        32'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h34, 1'b0, 32'h0,        32'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h12, 1'b1, 32'h12345678, 32'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 32'h12345678, 32'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 32'h12345678, 32'd0, 1'b0, 1'b0};

    rst = 1;
    repeat (2) @(posedge clk);
    do_reset();

    // First word through the table.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].d);
      check($sformatf("tbl%0d_wen", i),  32'(upg_wen),  32'(tbl[i].wen));
      check($sformatf("tbl%0d_dat", i),  upg_dat,       tbl[i].dat);
      check($sformatf("tbl%0d_adr", i),  32'(upg_adr),  tbl[i].adr);
      check($sformatf("tbl%0d_sel", i),  32'(upg_sel),  32'(tbl[i].sel));
      check($sformatf("tbl%0d_done", i), 32'(upg_done), 32'(tbl[i].done));
    end

    // Full image back to back: end by count, then ignore further bytes.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i));
      if (i == 15) check("full_done_at_last_wen", 32'({upg_wen, upg_done}), 32'b11);
    end
    step(1'b1, 8'h55);
    check("full_extra_wen", 32'(upg_wen), 32'd0);
    check("full_nwrites", 32'(log_dat.size()), 32'd4);
    if (log_dat.size() == 4) begin
      check("full_w0", log_dat[0], 32'h03020100);
      check("full_w1", log_dat[1], 32'h07060504);
      check("full_w2", log_dat[2], 32'h0B0A0908);
      check("full_w3", log_dat[3], 32'h0F0E0D0C);
      check("full_a", {log_adr[0][7:0], log_adr[1][7:0], log_adr[2][7:0], log_adr[3][7:0]}, 32'h00010001);
      check("full_s", 32'({log_sel[0], log_sel[1], log_sel[2], log_sel[3]}), 32'b0011);
    end

    // Partial word flushed after timeout.
    do_reset();
    step(1'b1, 8'hAA); step(1'b1, 8'hBB); step(1'b1, 8'hCC);
    step(1'b1, 8'hDD); step(1'b1, 8'hEE);
    idle(25);
    check("flush_nwrites", 32'(log_dat.size()), 32'd2);
    if (log_dat.size() == 2) begin
      check("flush_w0", log_dat[0], 32'hDDCCBBAA);
      check("flush_w1", log_dat[1], 32'h000000EE);
      check("flush_a1", log_adr[1], 32'd1);
      check("flush_s1", 32'(log_sel[1]), 32'd0);
    end
    check("flush_done", 32'(upg_done), 32'd1);

    // Whole word then timeout: no flush write.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i));
    idle(25);
    check("noflush_nwrites", 32'(log_dat.size()), 32'd1);
    check("noflush_done", 32'(upg_done), 32'd1);

    // Byte on the write-strobe cycle becomes byte 0 of the next word.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i));
    check("overlap_wen", 32'(upg_wen), 32'd1);
    step(1'b1, 8'h9A);
    step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h03);
    check("overlap_dat", upg_dat, 32'h0302019A);
    check("overlap_adr", 32'(upg_adr), 32'd1);

    // Reset mid-word discards it and restarts at address 0.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i));
    do_reset();
    check("rst_outs", {upg_dat[30:0] | {29'd0, upg_wen, upg_sel}, upg_done}, 32'd0);
    check("rst_adr", 32'(upg_adr), 32'd0);
    step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h03); step(1'b1, 8'h04);
    check("rst_dat", upg_dat, 32'h04030201);
    check("rst_adr_sel", {upg_adr, upg_sel, upg_wen}, {14'd0, 1'b0, 1'b1});

    // 19-cycle gaps never time out.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h80 + i));
      if (i != 7) idle(TMO - 1);
    end
    idle(1);
    check("gap_nwrites", 32'(log_dat.size()), 32'd2);
    check("gap_done", 32'(upg_done), 32'd0);
    if (log_dat.size() == 2) check("gap_w1", log_dat[1], 32'h87868584);

    // Random streams with mixed density and occasional long gaps.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int n = 0; n < 40; n++) begin
        if ($urandom_range(0, 7) == 0) idle($urandom_range(TMO - 3, TMO + 2));
        else idle($urandom_range(0, 3));
        step(1'b1, 8'($urandom));
      end
      idle(TMO + 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
